// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: stage count, width legality and mode encoding.
package adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int nstage(input int width, input int stage_w);
        return width / stage_w;
    endfunction

    function automatic bit width_ok(input int width, input int stage_w);
        return (stage_w > 0) && (width >= stage_w) && ((width % stage_w) == 0);
    endfunction

endpackage

// File: rtl/add_slice.sv
// Full-adder cell and the combinational W-bit ripple slice built from it; the slice
// also exposes the carry into its MSB so the top slice can derive signed overflow.
module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module add_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o,
    output logic         cmsb_o
);
    logic [W:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < W; i++) begin : g_bit
        fa u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (c[i]),
            .s_o (s_o[i]),
            .c_o (c[i+1])
        );
    end

    assign c_o    = c[W];
    assign cmsb_o = c[W-1];
endmodule

// File: rtl/pipe_adder_n.sv
// Pipelined ripple-carry adder/subtractor: one STAGE_W slice resolved per stage, carry
// registered between stages, global-enable valid/ready pipeline with backpressure.
module pipe_adder_n
    import adder_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STAGE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSTAGE = nstage(WIDTH, STAGE_W);

    if (!width_ok(WIDTH, STAGE_W)) begin : g_bad_width
        $error("pipe_adder_n: WIDTH must be a positive multiple of STAGE_W");
    end

    logic             adv;

    // a_q/b_q carry the operand slices not yet consumed; s_q holds the resolved lower sum.
    logic [WIDTH-1:0] a_q [NSTAGE];
    logic [WIDTH-1:0] b_q [NSTAGE];
    logic [WIDTH-1:0] s_q [NSTAGE];
    logic             c_q [NSTAGE];
    logic             v_q [NSTAGE];
    logic             ovf_q;

    logic [WIDTH-1:0] a_d  [NSTAGE];
    logic [WIDTH-1:0] b_d  [NSTAGE];
    logic [WIDTH-1:0] s_d  [NSTAGE];
    logic             c_d  [NSTAGE];
    logic             cm_d [NSTAGE];
    logic             v_d  [NSTAGE];
    logic             ovf_d;

    assign adv      = !v_q[NSTAGE-1] | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic [WIDTH-1:0]   a_in;
        logic [WIDTH-1:0]   b_in;
        logic [WIDTH-1:0]   s_in;
        logic               c_in;
        logic               v_in;
        logic [STAGE_W-1:0] s_slice;
        logic [WIDTH-1:0]   s_nx;

        // Stage 0 takes the raw beat; subtraction becomes a + ~b + 1 here.
        if (k == 0) begin : g_first
            assign a_in = a;
            assign b_in = (sub == SUB) ? ~b : b;
            assign s_in = '0;
            assign c_in = (sub == SUB) ? 1'b1 : cin;
            assign v_in = in_valid;
        end else begin : g_next
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign s_in = s_q[k-1];
            assign c_in = c_q[k-1];
            assign v_in = v_q[k-1];
        end

        add_slice #(.W(STAGE_W)) u_slice (
            .a_i    (a_in[k*STAGE_W +: STAGE_W]),
            .b_i    (b_in[k*STAGE_W +: STAGE_W]),
            .c_i    (c_in),
            .s_o    (s_slice),
            .c_o    (c_d[k]),
            .cmsb_o (cm_d[k])
        );

        always_comb begin
            s_nx                        = s_in;
            s_nx[k*STAGE_W +: STAGE_W] = s_slice;
        end

        assign a_d[k] = a_in;
        assign b_d[k] = b_in;
        assign s_d[k] = s_nx;
        assign v_d[k] = v_in;
    end

    assign ovf_d = cm_d[NSTAGE-1] ^ c_d[NSTAGE-1];

    // Data only loads behind a valid beat, so the output holds its last result across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTAGE; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NSTAGE; k++) begin
                v_q[k] <= v_d[k];
                if (v_d[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
            if (v_d[NSTAGE-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = v_q[NSTAGE-1];
    assign sum       = s_q[NSTAGE-1];
    assign cout      = c_q[NSTAGE-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder_n.sv
// Self-checking bench for pipe_adder_n (WIDTH=32, STAGE_W=8): directed corner beats plus a
// randomized backpressure stream scored against an arithmetic reference queue.
module tb_pipe_adder_n;
    localparam int WIDTH   = 32;
    localparam int STAGE_W = 8;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483647 - 64'sd1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int vectors     = 0;
    int miscompares = 0;
    logic [33:0] q[$];

    always #5 clk = ~clk;

    pipe_adder_n #(.WIDTH(WIDTH), .STAGE_W(STAGE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Expected {cout, ovf, sum} from plain signed/unsigned arithmetic.
    function automatic logic [33:0] ref_add(input logic [31:0] av, input logic [31:0] bv,
                                            input logic ci, input logic sb);
        longint      r;
        logic [63:0] u;
        logic [31:0] s;
        logic        co;
        if (sb) begin
            r  = longint'($signed(av)) - longint'($signed(bv));
            s  = av - bv;
            co = (av >= bv);
        end else begin
            r  = longint'($signed(av)) + longint'($signed(bv)) + longint'(ci);
            u  = 64'(av) + 64'(bv) + 64'(ci);
            s  = u[31:0];
            co = u[32];
        end
        return {co, (r > SMAX) || (r < SMIN), s};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle after driving, check this cycle's handshake/outputs and update the model.
    task automatic settle(output bit acc);
        logic [33:0] e;
        #1;
        acc = 1'b0;
        if (rst) begin
            q.delete();
            return;
        end
        chk("in_ready", 64'(in_ready), 64'(!out_valid | out_ready));
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("stale_beat", 64'(out_valid), 64'(0));
            end else if (out_ready) begin
                e = q.pop_front();
                chk("sum",  64'(sum),  64'(e[31:0]));
                chk("cout", 64'(cout), 64'(e[33]));
                chk("ovf",  64'(ovf),  64'(e[32]));
            end
        end
        if (in_valid && in_ready) begin
            q.push_back(ref_add(a, b, cin, sub));
            acc = 1'b1;
        end
    endtask

    task automatic directed(input string tag, input logic [31:0] av, input logic [31:0] bv,
                            input logic ci, input logic sb,
                            input logic [31:0] es, input logic ec, input logic eo);
        bit acc;
        a = av; b = bv; cin = ci; sub = sb;
        in_valid = 1'b1; out_ready = 1'b1;
        settle(acc);
        chk({tag, "_accept"}, 64'(acc), 64'(1));
        tick();
        in_valid = 1'b0; a = $urandom; b = $urandom;
        for (int i = 1; i < 4; i++) begin
            settle(acc);
            chk({tag, "_early"}, 64'(out_valid), 64'(0));
            tick();
        end
        settle(acc);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_sum"},   64'(sum),       64'(es));
        chk({tag, "_cout"},  64'(cout),      64'(ec));
        chk({tag, "_ovf"},   64'(ovf),       64'(eo));
        tick();
    endtask

    initial begin
        bit acc;
        int sent;
        int cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            settle(acc);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        settle(acc);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sum",       64'(sum),       64'(0));
        chk("rst_cout",      64'(cout),      64'(0));
        chk("rst_ovf",       64'(ovf),       64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        tick();

        directed("ripple",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("borrow",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("ovf_add",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("ovf_sub",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        sent = 0; cyc = 0;
        while (sent < 64 && cyc < 2000) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            settle(acc);
            if (acc) sent++;
            tick();
            cyc++;
        end
        chk("stream_sent", 64'(sent), 64'(64));

        in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
        while (q.size() > 0 && cyc < 100) begin
            settle(acc);
            tick();
            cyc++;
        end
        chk("stream_drained", 64'(q.size()), 64'(0));
        for (int i = 0; i < 6; i++) begin
            settle(acc);
            tick();
        end

        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            settle(acc);
            tick();
        end
        rst = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom;
        settle(acc);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        settle(acc);
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        tick();
        for (int i = 0; i < 6; i++) begin
            settle(acc);
            tick();
        end
        directed("post_rst", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_adder_n.md
# pipe_adder_n

Parametrised, pipelined ripple-carry adder/subtractor for the multiplier datapath. It replaces fixed-width combinational adders where the width or clock rate makes a single ripple chain too long. The operands are split into STAGE_W-bit slices, and one slice is resolved per pipeline stage, with the carry registered between stages. It adds carry-in, add/subtract mode, carry-out, signed overflow and a valid/ready handshake with backpressure. It sits between the partial-product generators and the final accumulation in the Vedic multiplier tree.

## Interface
- WIDTH, 32, operand and result width; must be an integer multiple of STAGE_W.
- STAGE_W, 8, bits resolved per pipeline stage; NSTAGE = WIDTH/STAGE_W, and NSTAGE must be at least 1.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0 computes a+b+cin; 1 computes a-b, i.e. a+~b+1, and cin is ignored.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; when sub=1, cout=1 means no borrow (a ≥ b unsigned).
- ovf  output  1  two's-complement overflow: the carry into the MSB XOR the carry out of the MSB.

## Operation
- Global-enable pipeline of NSTAGE register stages: adv = !out_valid | out_ready, and in_ready = adv.
- in_ready is a combinational function of out_ready and out_valid; there is no other combinational input-to-output path.
- A beat is accepted when in_valid & in_ready; it is captured into stage 0 together with its sub flag and effective carry-in.
  - Effective B is b when sub=0 and ~b when sub=1.
  - Effective carry-in is cin when sub=0 and 1 when sub=1.
- Stage k (k = 0..NSTAGE-1) adds slice k of A and effective B plus the carry registered by stage k-1 (stage 0 uses the effective carry-in). It registers:
  - the slice sum,
  - the slice carry-out,
  - the not-yet-consumed upper operand slices (skew registers),
  - the already-resolved lower sum slices (deskew registers),
  - a valid bit.
- The final stage also registers ovf, using the carry into bit WIDTH-1.
- When adv=0, every stage holds its contents, including valid bits and data.
- When adv=1, every stage shifts forward, and bubbles propagate as valid=0.
- Results leave in acceptance order; no beat is dropped or duplicated.
- Data registers of invalid stages are don't-care internally, but sum, cout and ovf must hold their last value while out_valid=0 after the first result. Before the first result they are 0.

## Timing
- Reset (rst=1 at an edge) clears all valid bits and all data, carry and ovf registers to 0 on that edge.
- After reset: out_valid=0, sum=0, cout=0, ovf=0, and in_ready=1.
- rst has priority over handshake activity in the same cycle. A beat offered during rst is not accepted, and in-flight beats are discarded.
- Latency is NSTAGE cycles from the accepting edge to out_valid=1, given no stall.
- Throughput is one beat per cycle while out_ready=1.
- A stall (out_valid=1, out_ready=0) freezes the whole pipeline, including any bubbles, and drops in_ready the same cycle.
- Simultaneous output pop and input push in one cycle is legal and lossless.
- Reset released with out_ready=0 is legal: in_ready stays 1 until a result reaches the output.
- NSTAGE=1 degenerates to a single registered adder with 1-cycle latency.

## Structure
- Shared package adder_pkg holds:
  - a function computing NSTAGE,
  - an elaboration-time check that WIDTH % STAGE_W == 0,
  - the mode encoding constants ADD=1'b0 and SUB=1'b1.
- One sub-module, add_slice: a combinational STAGE_W-bit ripple adder with carry-in, carry-out and carry-into-MSB. It is built from the existing ha/fa cells and instantiated NSTAGE times in a generate loop.
- The pipeline, skew/deskew registers and handshake live in pipe_adder_n. The expected size is about 150–250 lines.

## Test plan
All scenarios use WIDTH=32, STAGE_W=8, so latency is 4.
- Reset: hold rst for 2 cycles with random inputs, then release → out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- Carry ripple: A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0 → 4 cycles later sum=0x00000000, cout=1, ovf=0.
- Subtract with borrow: A=0x00000005, B=0x00000007, sub=1, cin=1 (ignored) → sum=0xFFFFFFFE, cout=0, ovf=0.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, sub=0, cin=0 → sum=0x80000000, cout=0, ovf=1.
  - Also 0x80000000 − 0x00000001 → sum=0x7FFFFFFF, ovf=1, cout=1.
- Backpressure stream: 64 random beats with in_valid and out_ready each toggled randomly → results match a reference model, in order, with no loss or duplication. in_ready must equal !out_valid | out_ready in every cycle.
- Reset mid-flight: 3 beats in flight, assert rst for 1 cycle → out_valid=0 on the next cycle and no stale beat ever emerges. A beat A=1, B=2 issued after reset gives sum=3 exactly 4 cycles later.
